// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard handshake bundle: issue request from decode,
// stall/issue/busy status and stall counter back from the scoreboard.
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 4,
  parameter int LAT_W      = 3,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic                  two_src;
  logic [REG_ADDR_W-1:0] src1;
  logic [REG_ADDR_W-1:0] src2;
  logic                  id_wb_en;
  logic [REG_ADDR_W-1:0] id_dest;
  logic [LAT_W-1:0]      id_lat;
  logic [LAT_W-1:0]      id_fwd_lat;
  logic                  flush;
  logic                  hazard_output;
  logic                  issue;
  logic                  busy;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output id_valid, two_src, src1, src2,
    output id_wb_en, id_dest, id_lat, id_fwd_lat,
    output flush,
    input  hazard_output, issue, busy, stall_cnt
  );

  modport slave (
    input  id_valid, two_src, src1, src2,
    input  id_wb_en, id_dest, id_lat, id_fwd_lat,
    input  flush,
    output hazard_output, issue, busy, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard for ID: per-register write countdowns,
// RAW/WAW stall, issue strobe, busy flag and saturating stall counter.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 4,
  parameter int LAT_W      = 3,
  parameter bit FWD_EN     = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_scoreboard_if.slave bus
);

  localparam int NREG = 2 ** REG_ADDR_W;

  typedef logic [LAT_W-1:0] lat_t;

  lat_t             wb_q [NREG];
  lat_t             wb_d [NREG];
  lat_t             fw_q [NREG];
  lat_t             fw_d [NREG];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  lat_t sel1;
  lat_t sel2;
  lat_t fwd_ld;
  logic raw1;
  logic raw2;
  logic waw;
  logic live;
  logic hazard;
  logic issue;
  logic load;
  logic busy;

  always_comb begin
    if (FWD_EN) begin
      sel1 = fw_q[bus.src1];
      sel2 = fw_q[bus.src2];
    end else begin
      sel1 = wb_q[bus.src1];
      sel2 = wb_q[bus.src2];
    end
  end

  // All terms look at current state only, so an
  // instruction never stalls on its own write.
  assign raw1   = (sel1 != '0);
  assign raw2   = bus.two_src && (sel2 != '0);
  assign waw    = bus.id_wb_en &&
                  (wb_q[bus.id_dest] > bus.id_lat);
  assign live   = bus.id_valid && !bus.flush;
  assign hazard = live && (raw1 || raw2 || waw);
  assign issue  = live && !hazard;
  assign load   = issue && bus.id_wb_en;

  // Forwarding can never be later than writeback.
  assign fwd_ld = (bus.id_fwd_lat > bus.id_lat) ?
                  bus.id_lat : bus.id_fwd_lat;

  always_comb begin
    busy = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      busy = busy || (wb_q[r] != '0);
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      wb_d[r] = wb_q[r];
      fw_d[r] = fw_q[r];
      if (wb_q[r] != '0) begin
        wb_d[r] = wb_q[r] - lat_t'(1);
      end
      if (fw_q[r] != '0) begin
        fw_d[r] = fw_q[r] - lat_t'(1);
      end
      // A fresh issue overrides the decrement.
      if (load &&
          (bus.id_dest == r[REG_ADDR_W-1:0])) begin
        wb_d[r] = bus.id_lat;
        fw_d[r] = fwd_ld;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hazard && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        wb_q[r] <= '0;
        fw_q[r] <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        wb_q[r] <= wb_d[r];
        fw_q[r] <= fw_d[r];
      end
      cnt_q <= cnt_d;
    end
  end

  assign bus.hazard_output = hazard;
  assign bus.issue         = issue;
  assign bus.busy          = busy;
  assign bus.stall_cnt     = cnt_q;

endmodule
